// File: rtl/alu_rol_seq.sv
// Iterative rotate-left unit: captures a 32-bit operand and a 5-bit count on start,
// rotates one bit per clock, and pulses done for one cycle when the result is ready.
module alu_rol_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] input_data,
  input  logic [4:0]  num_rotates,
  output logic [31:0] output_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  count;

  // Handshake: start is honoured only when the unit is not busy (IDLE or DONE);
  // done is a one-cycle pulse during which output_data carries the final result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= 32'h0;
      count <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work  <= input_data;
            count <= num_rotates;
            if (num_rotates == 5'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ROTATE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ROTATE: begin
          work  <= {work[30:0], work[31]};
          count <= count - 5'd1;
          // count is at least 1 here, so the decrement cannot wrap
          if (count == 5'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ROTATE;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign output_data = work;

endmodule

// File: tb/tb_alu_rol_seq.sv
// Directed bench for alu_rol_seq: a cycle-level behavioural model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_alu_rol_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] input_data;
  logic [4:0]  num_rotates;
  logic [31:0] output_data;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  alu_rol_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .input_data  (input_data),
    .num_rotates (num_rotates),
    .output_data (output_data),
    .busy        (busy),
    .done        (done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] x, input int k);
    int s;
    s = k % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // behavioural model: an operation is "remaining cycles until done" plus its operands
  bit          m_valid;
  bit          m_active;
  int          m_rem;
  int          m_k;
  logic [31:0] m_d;
  logic [31:0] m_last;
  logic [31:0] exp_q[$];

  initial begin
    m_valid  = 0;
    m_active = 0;
    m_rem    = 0;
    m_k      = 0;
    m_d      = '0;
    m_last   = '0;
  end

  always @(posedge clk) begin
    m_valid = 1;
    if (reset) begin
      m_active = 0;
      m_last   = '0;
      exp_q.delete();
    end else if ((!m_active || m_rem == 0) && start) begin
      m_active = 1;
      m_d      = input_data;
      m_k      = int'(num_rotates);
      m_rem    = m_k;
      exp_q.push_back(rol(input_data, int'(num_rotates)));
    end else if (m_active && m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (m_active) begin
      m_active = 0;
      m_last   = rol(m_d, m_k);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, sampled on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {31'b0, busy}, {31'b0, (m_active && m_rem > 0)});
      check("done", {31'b0, done}, {31'b0, (m_active && m_rem == 0)});
      check("output_data", output_data,
            m_active ? rol(m_d, m_k - m_rem) : m_last);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_without_op", 32'd1, 32'd0);
        end else begin
          check("sb_result", output_data, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks; all called at a falling edge
  task automatic pulse(input logic [31:0] d, input logic [4:0] k);
    start       = 1'b1;
    input_data  = d;
    num_rotates = k;
    @(negedge clk);
    start       = 1'b0;
    input_data  = $urandom;
    num_rotates = 5'($urandom_range(0, 31));
  endtask

  // waits for done starting at cycle c0 (current negedge), checks latency and result
  task automatic wait_done(input string name, input int c0, input int exp_cyc,
                           input logic [31:0] exp_out);
    int c;
    c = c0;
    while (!done && c <= 40) begin
      @(negedge clk);
      c++;
    end
    check({name, "_latency"}, 32'(c), 32'(exp_cyc));
    check({name, "_result"}, output_data, exp_out);
  endtask

  initial begin
    int dcount;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    start       = 1'b1;
    input_data  = 32'hDEADBEEF;
    num_rotates = 5'd3;

    // reset for two cycles with start high
    repeat (2) begin
      @(negedge clk);
      check("rst_out", output_data, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_out", output_data, 32'h0);

    // rotate by 1
    pulse(32'h80000001, 5'd1);
    check("r1_busy_c1", {31'b0, busy}, 32'd1);
    wait_done("r1", 1, 2, 32'h00000003);
    repeat (2) @(negedge clk);
    check("r1_hold", output_data, 32'h00000003);

    // rotate by 0
    pulse(32'h12345678, 5'd0);
    check("r0_busy_c1", {31'b0, busy}, 32'd0);
    wait_done("r0", 1, 1, 32'h12345678);
    @(negedge clk);

    // rotate by 4, then back-to-back rotate by 31 in the DONE cycle
    pulse(32'h12345678, 5'd4);
    wait_done("r4", 1, 5, 32'h23456781);
    pulse(32'h00000001, 5'd31);
    wait_done("r31", 1, 32, 32'h80000000);
    repeat (3) @(negedge clk);

    // start while busy is ignored
    pulse(32'hF0000000, 5'd8);
    repeat (2) @(negedge clk);
    start       = 1'b1;
    input_data  = 32'hA5A5A5A5;
    num_rotates = 5'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 4, 9, 32'h000000F0);
    repeat (2) @(negedge clk);

    // reset mid-operation
    pulse(32'h0F0F1234, 5'd20);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_out", output_data, 32'h0);
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mid_rst_no_done", 32'(dcount), 32'd0);

    // a fresh op after reset recovery
    pulse(32'hC0000003, 5'd2);
    wait_done("post_rst", 1, 3, 32'h0000000F);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rol_seq.md
# alu_rol_seq

Iterative rotate-left unit for the ALU datapath. It is the left-direction counterpart to the combinational rotate-right path. It accepts a 32-bit operand and a 5-bit rotate count on a start pulse, then rotates one bit position per clock. It reports completion with a single-cycle `done` pulse. It sits beside the combinational ALU functions and is used by the control unit for ROL instructions that tolerate multi-cycle latency.

## Interface
Parameters: none. Data width is fixed at 32 and count width at 5.

- `clk`  input  1  system clock; all state changes on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  request to begin a rotation; sampled on the rising edge
- `input_data`  input  32  operand; captured on an accepted `start`
- `num_rotates`  input  5  rotate-left amount 0..31; captured on an accepted `start`
- `output_data`  output  32  working/result register
- `busy`  output  1  high while rotation is in progress (ROTATE state)
- `done`  output  1  one-cycle pulse; `output_data` holds the final result in this cycle

## Operation
- State machine: IDLE, ROTATE, DONE. Reset state is IDLE.
- Internal registers:
  - `work` (32 bits) drives `output_data`.
  - `count` (5 bits) holds the remaining rotations.
- `start` is accepted only in IDLE or DONE. In ROTATE, `start` is ignored and the captured operands are not disturbed.
- On an accepted `start`:
  - `work <= input_data`, `count <= num_rotates`.
  - Next state is DONE if `num_rotates == 0`, otherwise ROTATE.
- In ROTATE, every cycle:
  - `work <= {work[30:0], work[31]}`, `count <= count - 1`.
  - When `count == 1` at the edge, next state is DONE. Otherwise stay in ROTATE.
- In DONE:
  - `done = 1`, `busy = 0`.
  - Next state is IDLE, unless `start` is asserted, in which case the new operation is accepted as above (back-to-back).
- In IDLE, `work` holds the last result.
- `output_data` is only meaningful while `done = 1` or in IDLE after a completed operation. In ROTATE it shows intermediate values.
- The result equals `input_data` rotated left by `num_rotates` mod 32. `count` never underflows.
- `busy` and `done` are decoded from state and are mutually exclusive.

## Timing
- Reset values: `output_data = 32'h0`, `busy = 0`, `done = 0`, `count = 0`, state IDLE.
- Latency: the cycle in which `start` is sampled is cycle 0. `done` is high in cycle `k + 1`, where `k = num_rotates`.
  - `k = 0` gives `done` in cycle 1.
  - `k = 31` gives `done` in cycle 32.
- `busy` is high in cycles 1..k when `k > 0`, and never high when `k = 0`.
- `done` is high for exactly one cycle per accepted `start`.
- Throughput with `start` held or re-pulsed in the DONE cycle: one operation every `k + 1` cycles, with no idle gap.
- Reset during ROTATE or DONE forces IDLE and the reset values on the next edge. The in-flight result is discarded and no `done` is produced.
- Reset has priority over `start` on the same edge.
- `input_data` and `num_rotates` may change freely after the accepting edge.

## Test plan
- Reset then idle: assert `reset` for 2 cycles with `start` high -> `output_data = 0`, `busy = 0`, `done = 0` throughout; no operation is accepted.
- `input_data = 32'h80000001`, `num_rotates = 1` -> `busy` high in cycle 1, `done` in cycle 2, `output_data = 32'h00000003`.
- `input_data = 32'h12345678`, `num_rotates = 0` -> `busy` never high, `done` in cycle 1, `output_data = 32'h12345678`.
- `input_data = 32'h12345678`, `num_rotates = 4` -> `done` in cycle 5 with `output_data = 32'h23456781`. Then `start` in the DONE cycle with `32'h00000001`, `num_rotates = 31` -> second `done` 32 cycles later with `output_data = 32'h80000000`.
- Start while busy: begin `32'hF0000000` rotated by 8, then pulse `start` with different operands in cycle 3 -> pulse ignored; `done` in cycle 9 with `output_data = 32'h000000F0`.
- Reset mid-operation: begin rotate by 20, assert `reset` in cycle 6 -> next cycle has `busy = 0` and `output_data = 0`, and no `done` pulse ever appears for that operation.
